word_assembler: RTL

Packs a stream of narrow CHUNK_WIDTH chunks into one INPUT_WIDTH word and presents it to a downstream `register` for loading. It sits directly upstream of a `register` instance: `output_data` drives the register's `input_data`, `load_data` drives its `load_data`, and `out_ready` is driven by the same signal as the register's `en`. A valid/ready handshake on the input side and a hold-until-accepted rule on the output side give zero-bubble throughput of one chunk per cycle.

---
 rtl/word_assembler.sv | 88 ++++++++
 1 files changed

// File: rtl/word_assembler.sv
// Packs CHUNK_WIDTH chunks into an INPUT_WIDTH word for a downstream register; word valid one cycle after last accept.
// Full word is held (load_data high) until out_ready drains it; drain and refill slot 0 can share one edge.
module word_assembler #(
   parameter int INPUT_WIDTH = 32,
   parameter int CHUNK_WIDTH = 8,
   parameter int LSB_FIRST   = 1,
   localparam int NUM_CHUNKS = INPUT_WIDTH / CHUNK_WIDTH,
   localparam int CNT_W      = $clog2(NUM_CHUNKS + 1)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clear,
   input  logic                   en,
   input  logic                   in_valid,
   input  logic [CHUNK_WIDTH-1:0] in_data,
   output logic                   in_ready,
   input  logic                   out_ready,
   output logic                   load_data,
   output logic [INPUT_WIDTH-1:0] output_data,
   output logic [CNT_W-1:0]       chunk_count
);

   typedef enum logic {FILL, FULL} state_t;

   localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(NUM_CHUNKS - 1);

   state_t                 state_q;
   logic [CNT_W-1:0]       cnt_q;
   logic [INPUT_WIDTH-1:0] buf_q;
   logic [INPUT_WIDTH-1:0] buf_d;
   logic [CNT_W-1:0]       slot;
   logic                   accept;

   // clear gates in_ready so a chunk presented alongside it is dropped, not half-written
   assign in_ready    = rst & ~clear & en & ((state_q == FILL) | out_ready);
   assign load_data   = en & (state_q == FULL);
   assign accept      = in_valid & in_ready;
   assign slot        = (state_q == FULL) ? '0 : cnt_q;
   assign output_data = buf_q;
   assign chunk_count = cnt_q;

   always_comb begin
      buf_d = buf_q;
      for (int k = 0; k < NUM_CHUNKS; k++) begin
         if (slot == CNT_W'(k)) begin
            buf_d[((LSB_FIRST != 0) ? k : (NUM_CHUNKS - 1 - k)) * CHUNK_WIDTH +: CHUNK_WIDTH] = in_data;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= FILL;
         cnt_q   <= '0;
         buf_q   <= '0;
      end else if (clear) begin
         state_q <= FILL;
         cnt_q   <= '0;
         buf_q   <= '0;
      end else if (en) begin
         if (accept) begin
            buf_q <= buf_d;
         end
         case (state_q)
            FILL: begin
               if (accept) begin
                  cnt_q <= cnt_q + CNT_W'(1);
                  if (cnt_q == LAST_SLOT) begin
                     state_q <= FULL;
                  end
               end
            end
            FULL: begin
               // accept in FULL implies out_ready, so it always coincides with a drain
               if (out_ready) begin
                  state_q <= FILL;
                  cnt_q   <= accept ? CNT_W'(1) : '0;
               end
            end
            default: begin
               state_q <= FILL;
               cnt_q   <= '0;
            end
         endcase
      end
   end

endmodule
